// File: rtl/fu_matrix_ls_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fu_matrix_ls_seq_pkg
//  Description : Shared types and constants for the matrix load/store
//                sequencer (state encoding, operation bundle, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package fu_matrix_ls_seq_pkg;

    localparam int MAT_ROWS     = 4;
    localparam int ROW_W        = 64;
    localparam int MATLS_ADDR_W = 32;
    localparam int MATLS_MREG_W = 4;

    // Row and response counters reach MAT_ROWS, so one extra bit beyond the row index
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ISSUE = 3'd1,
        S_LD_DRAIN = 3'd2,
        S_ST_READ  = 3'd3,
        S_ST_ISSUE = 3'd4,
        S_ST_DRAIN = 3'd5,
        S_DONE     = 3'd6
    } matls_state_t;

    typedef struct packed {
        logic [1:0]              ls;
        logic [MATLS_MREG_W-1:0] rd;
        logic [MATLS_ADDR_W-1:0] addr;
        logic [MATLS_ADDR_W-1:0] stride;
    } matls_op_t;

endpackage
`default_nettype wire

// File: rtl/fu_matrix_ls_seq_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : matls_addr_gen
//  Description : Row counter and running row address. Loads the base address
//                and stride when an op is accepted, then adds the stride on
//                every scratchpad request handshake (wraps mod 2^ADDR_W).
//  Revision    : 1.0 - initial release
// ============================================================================
module matls_addr_gen
    import fu_matrix_ls_seq_pkg::*;
#(
    parameter int ADDR_W = MATLS_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              step,
    output logic [CNT_W-1:0]  row,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] stride_q;

    // Base/stride capture on accept, then advance one row per handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row      <= '0;
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            row      <= '0;
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            row      <= row + CNT_W'(1);
            addr     <= addr + stride_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fu_matrix_ls_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fu_matrix_ls_seq
//  Description : Matrix load/store sequencer. Breaks one matrix LS op into
//                MAT_ROWS row transfers between the scratchpad and the matrix
//                register file, then pulses mhit once.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_matrix_ls_seq
    import fu_matrix_ls_seq_pkg::*;
#(
    parameter int MAT_ROWS = fu_matrix_ls_seq_pkg::MAT_ROWS,
    parameter int ROW_W    = fu_matrix_ls_seq_pkg::ROW_W,
    parameter int ADDR_W   = MATLS_ADDR_W,
    parameter int MREG_W   = MATLS_MREG_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_ls,
    input  logic [MREG_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_stride,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [ROW_W-1:0]  mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [ROW_W-1:0]  mem_rsp_rdata,
    output logic              mrf_wen,
    output logic [MREG_W-1:0] mrf_widx,
    output logic [1:0]        mrf_wrow,
    output logic [ROW_W-1:0]  mrf_wdata,
    output logic              mrf_ren,
    output logic [MREG_W-1:0] mrf_ridx,
    output logic [1:0]        mrf_rrow,
    input  logic [ROW_W-1:0]  mrf_rdata,
    output logic              mhit,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAT_ROWS - 1);

    matls_state_t      state;
    matls_state_t      state_nx;
    matls_op_t         op_in;
    logic [MREG_W-1:0] rd_q;
    logic [CNT_W-1:0]  rsp_cnt;
    logic [ROW_W-1:0]  wdata_q;
    logic              st_first;
    logic [CNT_W-1:0]  row;
    logic [ADDR_W-1:0] row_addr;
    logic              accept;
    logic              req_hs;
    logic              rsp_take;
    logic              rsp_last;
    logic              in_load;

    // Incoming op bundled as one record; only meaningful while req_valid
    assign op_in  = '{ls: req_ls, rd: req_rd, addr: req_addr, stride: req_stride};
    assign accept = req_valid & req_ready;
    assign req_hs = mem_req_valid & mem_req_ready;

    // Responses outside an active op (IDLE/DONE) are ignored entirely
    assign in_load  = (state == S_LD_ISSUE) || (state == S_LD_DRAIN);
    assign rsp_take = mem_rsp_valid &
                      (in_load || (state == S_ST_READ) ||
                       (state == S_ST_ISSUE) || (state == S_ST_DRAIN));
    assign rsp_last = rsp_take && (rsp_cnt == LAST_ROW);

    matls_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .CLK    (CLK),
        .RST    (RST),
        .load   (accept),
        .base   (op_in.addr),
        .stride (op_in.stride),
        .step   (req_hs),
        .row    (row),
        .addr   (row_addr)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Captured destination, response counter and store-data holding register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q     <= '0;
            rsp_cnt  <= '0;
            wdata_q  <= '0;
            st_first <= 1'b0;
        end else begin
            if (accept) begin
                rd_q    <= op_in.rd;
                rsp_cnt <= '0;
            end else if (rsp_take) begin
                rsp_cnt <= rsp_cnt + CNT_W'(1);
            end
            // RF read data is only valid on the first ST_ISSUE cycle; keep a copy for stalls
            st_first <= (state_nx == S_ST_ISSUE) && (state != S_ST_ISSUE);
            if ((state == S_ST_ISSUE) && st_first) begin
                wdata_q <= mrf_rdata;
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mrf_ren       = 1'b0;
        mhit          = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (op_in.ls[0]) begin
                        state_nx = S_LD_ISSUE;
                    end else if (op_in.ls[1]) begin
                        state_nx = S_ST_READ;
                    end
                end
            end
            S_LD_ISSUE: begin
                mem_req_valid = 1'b1;
                if (rsp_last) begin
                    state_nx = S_DONE;
                end else if (req_hs && (row == LAST_ROW)) begin
                    state_nx = S_LD_DRAIN;
                end
            end
            S_LD_DRAIN: begin
                if (rsp_last) begin
                    state_nx = S_DONE;
                end
            end
            S_ST_READ: begin
                mrf_ren  = 1'b1;
                state_nx = rsp_last ? S_DONE : S_ST_ISSUE;
            end
            S_ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (rsp_last) begin
                    state_nx = S_DONE;
                end else if (req_hs) begin
                    state_nx = (row == LAST_ROW) ? S_ST_DRAIN : S_ST_READ;
                end
            end
            S_ST_DRAIN: begin
                if (rsp_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                mhit     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Scratchpad request fields, zero whenever no request is offered
    always_comb begin
        mem_req_wen   = (state == S_ST_ISSUE);
        mem_req_addr  = mem_req_valid ? row_addr : '0;
        mem_req_wdata = '0;
        if (state == S_ST_ISSUE) begin
            mem_req_wdata = st_first ? mrf_rdata : wdata_q;
        end
    end

    // Matrix RF ports: load responses write straight through, store reads by row
    always_comb begin
        mrf_wen   = rsp_take & in_load;
        mrf_widx  = mrf_wen ? rd_q : '0;
        mrf_wrow  = mrf_wen ? rsp_cnt[1:0] : 2'd0;
        mrf_wdata = mrf_wen ? mem_rsp_rdata : '0;
        mrf_ridx  = mrf_ren ? rd_q : '0;
        mrf_rrow  = mrf_ren ? row[1:0] : 2'd0;
        busy      = (state != S_IDLE);
    end

endmodule
`default_nettype wire

// File: doc/fu_matrix_ls_seq.md
FU_MATRIX_LS_SEQ -- requirements
Module: fu_matrix_ls_seq

Interface
REQ-001 SHALL have parameters: MAT_ROWS 4 (rows per matrix); ROW_W 64 (bits per row, 4 x FP16); ADDR_W 32; MREG_W 4 (matrix register index width).
REQ-002 SHALL have one clock and an asynchronous, active-high reset. Ports:
  CLK            in   1       clock
  RST            in   1       async active-high reset
  req_valid      in   1       matrix LS op from matrix LS FU
  req_ready      out  1       sequencer can accept op
  req_ls         in   2       bit0 load, bit1 store
  req_rd         in   MREG_W  matrix register (load dest / store source)
  req_addr       in   ADDR_W  base address of row 0
  req_stride     in   ADDR_W  byte stride between rows
  mem_req_valid  out  1       scratchpad request valid
  mem_req_ready  in   1       scratchpad accepts request
  mem_req_wen    out  1       1 write, 0 read
  mem_req_addr   out  ADDR_W  row address
  mem_req_wdata  out  ROW_W   store row data
  mem_rsp_valid  in   1       read data / write ack, in order
  mem_rsp_rdata  in   ROW_W   read data
  mrf_wen        out  1       matrix RF row write
  mrf_widx       out  MREG_W  matrix RF write register
  mrf_wrow       out  2       matrix RF write row
  mrf_wdata      out  ROW_W   matrix RF write data
  mrf_ren        out  1       matrix RF row read
  mrf_ridx       out  MREG_W  matrix RF read register
  mrf_rrow       out  2       matrix RF read row
  mrf_rdata      in   ROW_W   valid the cycle after mrf_ren
  mhit           out  1       one-cycle completion pulse to FU
  busy           out  1       state != IDLE

Function
REQ-003 SHALL implement FSM states IDLE, LD_ISSUE, LD_DRAIN, ST_READ, ST_ISSUE, ST_DRAIN, DONE.
REQ-004 SHALL assert req_ready only in IDLE; op accepted on req_valid & req_ready; req_rd, req_addr, req_stride captured.
REQ-005 SHALL decode req_ls: bit0 set -> load (priority when both set); only bit1 -> store; 2'b00 -> accepted, dropped, stays IDLE, no mhit.
REQ-006 SHALL form row r address as req_addr + r*req_stride mod 2^ADDR_W via running adder; stride 0 legal.
REQ-007 Load: LD_ISSUE drives mem_req_valid, wen=0 for rows 0..3, advancing row on each handshake; after row 3 accepted -> LD_DRAIN.
REQ-008 Load: each mem_rsp_valid (accepted in LD_ISSUE or LD_DRAIN) writes mrf row = response count, widx = captured rd, same cycle; 4th response -> DONE.
REQ-009 Store: ST_READ asserts mrf_ren for row r for one cycle; ST_ISSUE registers mrf_rdata on entry and holds mem_req_valid, wen=1, stable addr/wdata until mem_req_ready; then r+1 -> ST_READ, or after row 3 -> ST_DRAIN.
REQ-010 Store: write acks counted in ST_READ/ST_ISSUE/ST_DRAIN; 4th ack -> DONE.
REQ-011 SHALL hold mem_req_addr/wen/wdata stable while mem_req_valid & !mem_req_ready.
REQ-012 DONE SHALL assert mhit for exactly one cycle, then IDLE; next op accepted earliest the cycle after mhit.
REQ-013 Load latency, ready always high and 1-cycle response: accept at cycle 0, requests cycles 1-4, mrf writes cycles 2-5, mhit cycle 6.
REQ-014 mem_rsp_valid in IDLE or DONE SHALL be ignored (no mrf write, no counter change).
REQ-015 Row and response counters SHALL be 3 bits; no wrap, since completion triggers at 4.

Reset
REQ-016 On RST: state IDLE, counters 0, captured registers 0; all outputs 0 except req_ready=1.
REQ-017 Reset mid-op SHALL abort with no mhit; responses after reset are dropped per REQ-014.

Structure
REQ-018 Shared package SHALL hold matls_state_t, MAT_ROWS, ROW_W, and a matls_op_t struct {ls, rd, addr, stride}.
REQ-019 A sub-module matls_addr_gen SHALL hold the row counter and running address (load base, step on handshake).

Verification
REQ-020 Load rd=3, addr=0x100, stride=0x20, ready=1, 1-cycle rsp -> reads 0x100/0x120/0x140/0x160; mrf rows 0-3 of reg 3; mhit at cycle 6.
REQ-021 Store rd=5, addr=0x200, stride=0x8, ready low 2 cycles per request -> 4 writes to 0x200-0x218 with reg 5 rows 0-3; request fields stable while stalled; mhit after 4th ack.
REQ-022 req_ls=2'b11 -> load; req_ls=2'b00 -> no mem traffic, no mhit, req_ready stays 1.
REQ-023 addr=0xFFFFFFF0, stride=0x10 -> addresses 0xFFFFFFF0, 0x0, 0x10, 0x20; stride 0 -> four reads of the same address.
REQ-024 RST after 2nd load request; late rsp_valid after reset -> no mrf_wen, no mhit, req_ready=1 the cycle after reset release.
